mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: IDLE/ACCESS/DONE handshake with data memory, registered results to MEM/WB.
// Optional access timeout enabled by defining MEM_STAGE_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module mem_stage #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] ALU,
  input  logic [31:0] dato_wr,
  input  logic [4:0]  rd,
  input  logic [4:0]  rt,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] dato_mem,
  output logic [31:0] ALU_out,
  output logic [4:0]  rd_out,
  output logic [4:0]  rt_out,
  output logic        stall,
  output logic        mem_err
);

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [31:0] lat_alu, lat_wdata;
  logic [4:0]  lat_rd, lat_rt;
  logic        lat_we;
  logic [7:0]  to_cnt;

  logic req_any, aligned;
  assign req_any = mem_read | mem_write;
  assign aligned = (ALU[1:0] == 2'b00);

  // DONE releases stall even if a new access is presented; the request is latched on that edge.
  assign stall      = ((state == IDLE) && req_any && aligned) || (state == ACCESS);
  assign dmem_we    = lat_we;
  assign dmem_addr  = lat_alu;
  assign dmem_wdata = lat_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dato_mem  <= '0;
      ALU_out   <= '0;
      rd_out    <= '0;
      rt_out    <= '0;
      mem_err   <= 1'b0;
      dmem_req  <= 1'b0;
      to_cnt    <= '0;
      lat_alu   <= '0;
      lat_wdata <= '0;
      lat_rd    <= '0;
      lat_rt    <= '0;
      lat_we    <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        ACCESS: begin
          if (dmem_ack) begin
            dato_mem <= lat_we ? 32'h0 : dmem_rdata;
            ALU_out  <= lat_alu;
            rd_out   <= lat_rd;
            rt_out   <= lat_rt;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (TO_EN && to_cnt == TO_LIM) begin
            dato_mem <= '0;
            rd_out   <= '0;
            rt_out   <= '0;
            mem_err  <= 1'b1;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          if (req_any && aligned) begin
            lat_alu   <= ALU;
            lat_wdata <= dato_wr;
            lat_rd    <= rd;
            lat_rt    <= rt;
            lat_we    <= mem_write;
            rd_out    <= '0;
            rt_out    <= '0;
            to_cnt    <= '0;
            dmem_req  <= 1'b1;
            state     <= ACCESS;
          end else begin
            // Plain pass-through, or a misaligned access squashed into a bubble with an error pulse.
            ALU_out  <= ALU;
            dato_mem <= '0;
            rd_out   <= req_any ? 5'd0 : rd;
            rt_out   <= req_any ? 5'd0 : rt;
            mem_err  <= req_any;
          end
        end
      endcase
    end
  end

endmodule
